// File: rtl/div_47by24_seq.sv
// Sequential restoring divider: 47-bit dividend / 24-bit divisor -> 24-bit quotient and remainder.
// Define DIV_47BY24_RADIX4_EN to retire two quotient bits per CALC cycle instead of one.
module div_47by24_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [46:0] dividend,
  input  logic [23:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] quotient,
  output logic [23:0] remainder,
  output logic        div_zero,
  output logic        ovf
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // producer holds its payload stable until then, and ready never depends on valid.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

`ifdef DIV_47BY24_RADIX4_EN
  localparam logic [4:0] LAST_CNT = 5'd11;
`else
  localparam logic [4:0] LAST_CNT = 5'd23;
`endif

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [23:0] rem;
  logic [23:0] q;
  logic [23:0] dvd_lo;
  logic [23:0] dvs;
  logic        err_zero;
  logic        err_ovf;

  logic [23:0] rem_next;
  logic [23:0] q_next;
  logic [23:0] dvd_next;

  // One restoring step; result is {new_rem, quotient_bit}. rem < dvs keeps new_rem in 24 bits.
  function automatic logic [24:0] div_step(input logic [23:0] r, input logic b,
                                           input logic [23:0] d);
    logic [24:0] rp;
    logic [24:0] diff;
    rp   = {r, b};
    diff = rp - {1'b0, d};
    if (rp >= {1'b0, d}) div_step = {diff[23:0], 1'b1};
    else                 div_step = {rp[23:0], 1'b0};
  endfunction

`ifdef DIV_47BY24_RADIX4_EN
  logic [24:0] s1;
  logic [24:0] s2;
  always_comb begin
    s1       = div_step(rem, dvd_lo[23], dvs);
    s2       = div_step(s1[24:1], dvd_lo[22], dvs);
    rem_next = s2[24:1];
    q_next   = {q[21:0], s1[0], s2[0]};
    dvd_next = {dvd_lo[21:0], 2'b00};
  end
`else
  logic [24:0] s1;
  always_comb begin
    s1       = div_step(rem, dvd_lo[23], dvs);
    rem_next = s1[24:1];
    q_next   = {q[22:0], s1[0]};
    dvd_next = {dvd_lo[22:0], 1'b0};
  end
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rem       <= '0;
      q         <= '0;
      dvd_lo    <= '0;
      dvs       <= '0;
      err_zero  <= 1'b0;
      err_ovf   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            dvs      <= divisor;
            dvd_lo   <= dividend[23:0];
            rem      <= {1'b0, dividend[46:24]};
            q        <= '0;
            cnt      <= '0;
            err_zero <= (divisor == 24'd0);
            err_ovf  <= (divisor != 24'd0) && ({1'b0, dividend[46:24]} >= divisor);
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          // Error operations spend a single cycle here so their latency is one cycle.
          if (err_zero || err_ovf) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= err_zero;
            ovf       <= err_ovf;
            state     <= S_DONE;
          end else begin
            rem    <= rem_next;
            q      <= q_next;
            dvd_lo <= dvd_next;
            cnt    <= cnt + 5'd1;
            if (cnt == LAST_CNT) begin
              quotient  <= q_next;
              remainder <= rem_next;
              div_zero  <= 1'b0;
              ovf       <= 1'b0;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_47by24_seq.sv
// Randomised scoreboard bench for div_47by24_seq against an arithmetic reference model.
module tb_div_47by24_seq;

  localparam int W = 50;  // {div_zero, ovf, quotient, remainder}
`ifdef DIV_47BY24_RADIX4_EN
  localparam int LAT = 12;
`else
  localparam int LAT = 24;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [46:0] dividend = '0;
  logic [23:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] quotient;
  logic [23:0] remainder;
  logic        div_zero;
  logic        ovf;

  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  int           lat_q[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic         rand_ready = 1'b0;
  logic         ov_prev = 1'b0;

  div_47by24_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_zero(div_zero), .ovf(ovf)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model from the arithmetic definition of floor division
  function automatic logic [W-1:0] model(input logic [46:0] a, input logic [23:0] b);
    logic [63:0] q64;
    logic [63:0] r64;
    if (b == 24'd0) return {1'b1, 1'b0, 24'hFFFFFF, 24'd0};
    q64 = {17'd0, a} / {40'd0, b};
    if (q64 > 64'hFFFFFF) return {1'b0, 1'b1, 24'hFFFFFF, 24'd0};
    r64 = {17'd0, a} - q64 * {40'd0, b};
    return {2'b00, q64[23:0], r64[23:0]};
  endfunction

  task automatic do_op(input logic [46:0] a, input logic [23:0] b);
    logic [W-1:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'd1);
      return;
    end
    e = model(a, b);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    exp_q.push_back(e);
    acc_q.push_back(cyc + 1);
    lat_q.push_back((e[49] || e[48]) ? 1 : LAT);
    @(negedge clk);
    in_valid = 1'b0;
    dividend = {$urandom(), $urandom()};
    divisor  = 24'($urandom());
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_op();
    logic [23:0] b;
    logic [63:0] qv;
    logic [63:0] rv;
    logic [63:0] a;
    int sel;
    sel = $urandom_range(0, 9);
    b = 24'($urandom());
    if (sel == 0) b = 24'd0;
    if (sel == 1) b = 24'($urandom_range(1, 255));
    if (sel == 2) a = {$urandom(), $urandom()};
    else begin
      if (b == 24'd0) qv = 64'($urandom());
      else qv = 64'($urandom()) & 64'hFFFFFF;
      rv = (b == 24'd0) ? 64'd0 : 64'($urandom()) % {40'd0, b};
      a  = qv * {40'd0, b} + rv;
    end
    do_op(a[46:0], b);
  endtask

  // Monitor: latency on out_valid rise, payload on handshake
  always @(negedge clk) begin
    #1;
    if (!rst_n) ov_prev = 1'b0;
    else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) check("unexpected_valid", 64'd1, 64'd0);
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(lat_q.pop_front()));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_result", 64'd1, 64'd0);
        else check("result", {14'd0, div_zero, ovf, quotient, remainder}, {14'd0, exp_q.pop_front()});
      end
      ov_prev = out_valid;
    end
  end

  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

  initial begin
    logic [W-1:0] e;
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_outputs", {quotient, remainder, out_valid, div_zero, ovf}, 64'd0);
    rst_n = 1'b1;

    // Directed cases
    do_op(47'h464A3A0000, 24'h04D200);
    do_op(47'h464A3A0005, 24'h04D200);
    do_op(47'h123456789AB, 24'h000000);
    do_op(47'h7FFFFFFFFFFF, 24'h000001);
    do_op(47'h000000FFFFFF, 24'h000001);
    do_op(47'h000001000000, 24'h000001);
    do_op(47'h7FFFFFFFFFFF, 24'hFFFFFF);
    wait_drain();

    // Hold result with out_ready low; new requests must be ignored
    out_ready = 1'b0;
    e = model(47'h464A3A0005, 24'h04D200);
    do_op(47'h464A3A0005, 24'h04D200);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_rise", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 47'h0000_0000_0007;
      divisor  = 24'h000002;
      @(negedge clk);
      check("hold_stable", {out_valid, in_ready, div_zero, ovf, quotient, remainder},
            {2'b10, e});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_handshake", {out_valid, in_ready}, 64'b01);

    // Reset in the middle of a calculation
    do_op(47'h464A3A0000, 24'h04D200);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midcalc_reset", {out_valid, in_ready, quotient, remainder}, {2'b01, 48'd0});
    exp_q.delete();
    acc_q.delete();
    lat_q.delete();
    rst_n = 1'b1;
    do_op(47'(64'h3E800 * 64'h3E900), 24'h03E900);
    wait_drain();

    // Random traffic with a stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) rand_op();
    wait_drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("final_queue_empty", 64'(acc_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
